// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with held grants and back-to-back handoff.
// Define ARB_TIMEOUT_EN to force release of a grant after MAX_HOLD cycles.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned INIT_PTR = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);
    localparam int unsigned N    = 8;
    localparam int unsigned IDW  = 3;
    localparam int unsigned CNTW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] gnt_id_nxt;
    logic           gnt_valid_nxt;
    logic           timeout_nxt;
    logic [N-1:0]   cand;
    logic [IDW-1:0] scan_base;
    logic [IDW:0]   pick;
    logic           owner_release;
    logic           force_rel;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
    end
    if (INIT_PTR > N - 1) begin : g_bad_init_ptr
        $error("rr_arbiter_8: INIT_PTR must be in 0..7");
    end

    // First set bit of r scanning upward from p+1 with wrap; p itself is lowest priority.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW:0]   res;
        logic [IDW-1:0] k;
        res = '0;
        for (int i = int'(N); i >= 1; i--) begin
            k = p + IDW'(i);
            if (r[k]) begin
                res = {1'b1, k};
            end
        end
        return res;
    endfunction

    // While granted, the scan starts after the owner and the owner is excluded.
    assign scan_base = (state == GRANT) ? gnt_id : ptr;
    assign cand      = (state == GRANT) ? (req & ~gnt) : req;
    assign pick      = rr_pick(cand, scan_base);

`ifdef ARB_TIMEOUT_EN
    logic [CNTW-1:0] hold_cnt;
    logic [CNTW-1:0] hold_cnt_nxt;

    assign force_rel = (state == GRANT) && (hold_cnt == CNTW'(MAX_HOLD - 1)) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        hold_cnt_nxt = hold_cnt;
        if (state == IDLE || owner_release || !enable) begin
            hold_cnt_nxt = '0;
        end else begin
            hold_cnt_nxt = hold_cnt + CNTW'(1);
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    assign owner_release = done || !req[gnt_id] || force_rel;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_nxt       = gnt;
        gnt_id_nxt    = gnt_id;
        gnt_valid_nxt = gnt_valid;
        timeout_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                gnt_nxt       = '0;
                gnt_id_nxt    = '0;
                gnt_valid_nxt = 1'b0;
                if (enable && pick[IDW]) begin
                    state_nxt     = GRANT;
                    gnt_nxt       = N'(1) << pick[IDW-1:0];
                    gnt_id_nxt    = pick[IDW-1:0];
                    gnt_valid_nxt = 1'b1;
                end
            end
            GRANT: begin
                if (!enable) begin
                    state_nxt     = IDLE;
                    ptr_nxt       = gnt_id;
                    gnt_nxt       = '0;
                    gnt_id_nxt    = '0;
                    gnt_valid_nxt = 1'b0;
                end else if (owner_release) begin
                    ptr_nxt     = gnt_id;
                    timeout_nxt = force_rel;
                    if (pick[IDW]) begin
                        gnt_nxt       = N'(1) << pick[IDW-1:0];
                        gnt_id_nxt    = pick[IDW-1:0];
                        gnt_valid_nxt = 1'b1;
                    end else begin
                        state_nxt     = IDLE;
                        gnt_nxt       = '0;
                        gnt_id_nxt    = '0;
                        gnt_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= IDW'(INIT_PTR);
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8 against a cycle model of the arbiter.
// Builds with or without ARB_TIMEOUT_EN; MAX_HOLD is set to 4 here.
module tb_rr_arbiter_8;
    localparam int unsigned MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // Model state
    bit m_valid;
    int m_id;
    int m_ptr;
    int m_cnt;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .INIT_PTR(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .req(req),
        .done(done),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .gnt_valid(gnt_valid),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic int rr_scan(input logic [7:0] r, input int p);
        for (int k = 1; k <= 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 7;
        m_cnt   = 0;
    endtask

    // Advance the model by one edge using the inputs the DUT is about to sample.
    task automatic model_step(output exp_t e);
        int         win;
        bit         fire;
        logic [7:0] c;
        win  = -1;
        fire = 1'b0;
        if (!m_valid) begin
            if (enable && req != 8'h00) win = rr_scan(req, m_ptr);
        end else if (!enable) begin
            m_ptr   = m_id;
            m_valid = 1'b0;
        end else begin
            fire = TO_EN && (m_cnt == int'(MAX_HOLD) - 1) && !done;
            if (done || !req[m_id] || fire) begin
                m_ptr   = m_id;
                c       = req;
                c[m_id] = 1'b0;
                m_valid = 1'b0;
                if (c != 8'h00) win = rr_scan(c, m_ptr);
            end else begin
                m_cnt++;
            end
        end
        if (win >= 0) begin
            m_valid = 1'b1;
            m_id    = win;
            m_cnt   = 0;
        end
        e.gnt   = m_valid ? (8'h01 << m_id) : 8'h00;
        e.id    = m_valid ? 3'(m_id) : 3'd0;
        e.valid = m_valid;
        e.to    = fire;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
        chk({tag, ".id"}, 32'(gnt_id), 32'(e.id));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(e.valid));
        chk({tag, ".timeout"}, 32'(timeout), 32'(e.to));
    endtask

    task automatic drive(input logic en, input logic [7:0] r, input logic d);
        enable = en;
        req    = r;
        done   = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h0);
        chk({tag, ".id"}, 32'(gnt_id), 32'h0);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'h0);
        chk({tag, ".timeout"}, 32'(timeout), 32'h0);
    endtask

    initial begin
        bit saw_to;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Single requester, then asynchronous reset mid-grant
        drive(1'b1, 8'h01, 1'b0);
        tick("r0_grant");
        chk("r0_id", 32'(gnt_id), 32'd0);
        tick("r0_hold");
        #2 rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        #2 rst_n = 1'b1;

        // Full request, done held: rotate 0..7,0 with no idle cycle
        drive(1'b1, 8'hFF, 1'b0);
        tick("rot_first");
        chk("rot_id0", 32'(gnt_id), 32'd0);
        done = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick("rot");
            chk($sformatf("rot_id%0d", i), 32'(gnt_id), 32'(i % 8));
            chk("rot_valid", 32'(gnt_valid), 32'd1);
        end
        drive(1'b1, 8'h00, 1'b0);
        tick("rot_withdraw");

        // Owner 3, handoff to 5, then release with no other requester
        drive(1'b1, 8'h08, 1'b0);
        tick("h3_grant");
        chk("h3_id", 32'(gnt_id), 32'd3);
        drive(1'b1, 8'h28, 1'b1);
        tick("h5_handoff");
        chk("h5_id", 32'(gnt_id), 32'd5);
        drive(1'b1, 8'h20, 1'b1);
        tick("h5_release");
        chk("h5_idle_valid", 32'(gnt_valid), 32'd0);
        chk("h5_idle_gnt", 32'(gnt), 32'd0);
        drive(1'b1, 8'h00, 1'b0);
        tick("h5_quiet");

        // Enable drop revokes, blocks, then re-grant after enable returns
        drive(1'b1, 8'h04, 1'b0);
        tick("e2_grant");
        chk("e2_id", 32'(gnt_id), 32'd2);
        enable = 1'b0;
        tick("e2_revoke");
        chk("e2_revoke_valid", 32'(gnt_valid), 32'd0);
        repeat (3) tick("e2_blocked");
        chk("e2_blocked_valid", 32'(gnt_valid), 32'd0);
        enable = 1'b1;
        tick("e2_regrant");
        chk("e2_regrant_id", 32'(gnt_id), 32'd2);
        chk("e2_regrant_valid", 32'(gnt_valid), 32'd1);

        // Owner 6 withdraws; 0 then beats 6
        drive(1'b1, 8'h00, 1'b0);
        tick("w_clear");
        req = 8'h40;
        tick("w6_grant");
        chk("w6_id", 32'(gnt_id), 32'd6);
        req = 8'h00;
        tick("w6_withdraw");
        chk("w6_withdraw_valid", 32'(gnt_valid), 32'd0);
        req = 8'h41;
        tick("w0_grant");
        chk("w0_id", 32'(gnt_id), 32'd0);
        done = 1'b1;
        tick("w6_after");
        chk("w6_after_id", 32'(gnt_id), 32'd6);

        // Done together with enable=0 goes idle; non-owner req churn is invisible
        drive(1'b0, 8'h41, 1'b1);
        tick("de_idle");
        chk("de_idle_valid", 32'(gnt_valid), 32'd0);
        drive(1'b1, 8'h10, 1'b0);
        tick("churn_grant");
        for (int i = 0; i < 6; i++) begin
            req = 8'h10 | 8'($urandom());
            tick("churn");
            chk("churn_id", 32'(gnt_id), 32'd4);
        end

        // Long hold with two requesters and no done
        drive(1'b1, 8'h00, 1'b0);
        tick("to_clear");
        req = 8'h03;
        tick("to_grant");
        chk("to_grant_id", 32'(gnt_id), 32'd0);
`ifdef ARB_TIMEOUT_EN
        repeat (3) tick("to_hold");
        chk("to_hold_id", 32'(gnt_id), 32'd0);
        tick("to_fire");
        chk("to_fire_pulse", 32'(timeout), 32'd1);
        chk("to_fire_id", 32'(gnt_id), 32'd1);
        tick("to_after");
        chk("to_after_pulse", 32'(timeout), 32'd0);
        repeat (20) tick("to_cycle");
`else
        saw_to = 1'b0;
        for (int i = 0; i < 110; i++) begin
            tick("to_hold");
            saw_to = saw_to | timeout;
        end
        chk("to_hold_id", 32'(gnt_id), 32'd0);
        chk("to_never", 32'(saw_to), 32'd0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 9) != 0), 8'($urandom()) & 8'($urandom()),
                  ($urandom_range(0, 3) == 0));
            tick("rand");
            chk("rand_onehot", 32'(gnt), 32'(gnt_valid ? (8'h01 << gnt_id) : 8'h00));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter that shares one downstream resource, such as the shared 8-to-3 encoded datapath slot.
- Produces a one-hot grant and its 3-bit encoded index. The winner holds the grant until it signals done.
- Rotating priority ensures no requester starves.
- Sits between the requester agents and the shared resource; the gnt_id output drives the resource's select input.

Parameters:
- MAX_HOLD, 16: maximum grant tenure in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- INIT_PTR, 7: last-granted pointer value after reset. The default gives requester 0 top priority on the first arbitration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  arbiter enable; 0 blocks new grants and revokes any active grant
- req  input  8  request vector; bit i = requester i
- done  input  1  release strobe from the current owner, sampled only while gnt_valid=1
- gnt  output  8  one-hot grant, registered
- gnt_id  output  3  encoded index of the granted requester, registered
- gnt_valid  output  1  high while a grant is held, registered
- timeout  output  1  one-cycle pulse on forced release (tied 0 without ARB_TIMEOUT_EN)

Behaviour:
- Reset: asserting rst_n=0 takes effect immediately, asynchronously, regardless of clk. It forces:
  - gnt=8'b0, gnt_id=3'd0, gnt_valid=0, timeout=0
  - state=IDLE, ptr=INIT_PTR, hold_cnt=0
- Reset mid-grant drops the grant with no done required.
- States: IDLE and GRANT, 1-bit state register.
- Arbitration function:
  - Scan req starting at index (ptr+1) mod 8, ascending with wrap from 7 to 0.
  - The first set bit wins. The previous owner is therefore lowest priority.
- IDLE:
  - If enable=1 and req!=0: at the next edge, load gnt/gnt_id with the winner, set gnt_valid=1, go to GRANT.
  - Latency: req asserted at edge N is sampled at edge N+1, and the grant is visible after edge N+1.
  - Otherwise remain in IDLE with outputs at 0.
- GRANT:
  - Outputs hold stable.
  - Release condition is any of: done=1; req[gnt_id]=0 (owner withdrew); or forced timeout.
  - On release at an edge: ptr<=gnt_id.
    - If other bits of req (excluding the releasing owner when done=1 or on timeout) are set and enable=1, grant the next winner at that same edge. Back-to-back handoff, no idle cycle, gnt_valid stays 1.
    - Otherwise clear the outputs and go to IDLE.
  - A releasing owner that still requests may re-win only if no other requester is pending.
  - enable=0 in GRANT: at the next edge clear gnt/gnt_id/gnt_valid and go to IDLE. ptr is updated to gnt_id. Outputs are never nonzero while disabled, except during that one cycle.
- done while in IDLE: ignored.
- Simultaneous events:
  - done together with enable=0: the enable rule wins, giving IDLE.
  - Reset dominates everything.
- gnt is always one-hot or zero, and gnt == (gnt_valid << gnt_id).
- req changes on non-owner bits during GRANT do not affect outputs.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8-bit) clears on every new grant and increments each cycle in GRANT.
  - When hold_cnt==MAX_HOLD-1 and no done, the next edge forces release, with handoff per the release rules (owner excluded).
  - timeout pulses 1 for exactly one cycle, aligned with the new grant or the return to IDLE.
  - A grant therefore never exceeds MAX_HOLD cycles.
- Undefined: no counter is built, timeout is tied to 0, and a grant holds indefinitely until done, owner withdrawal, or enable=0.

Test Plan:
- Reset then enable=1, req=8'h01 -> one cycle later gnt=8'h01, gnt_id=0, gnt_valid=1; assert rst_n=0 mid-grant -> all outputs 0 immediately, without waiting for a clk edge.
- req=8'hFF held, done pulsed each grant -> gnt_id sequence 0,1,2,...,7,0 with no idle cycles between grants.
- Owner id 3 granted, req=8'h28, done=1 -> next edge gnt_id=5; then done with req=8'h20 only -> IDLE, outputs 0.
- Owner id 2 holding, enable dropped to 0 -> next edge gnt_valid=0; req=8'h04 while enable=0 -> no grant; enable back to 1 -> gnt_id=2 one cycle later.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 with no done -> id 0 held 4 cycles, then timeout pulse and gnt_id=1; without the macro, id 0 holds for 100+ cycles and timeout stays 0.
- Owner id 6 drops req[6] with no done -> release next edge, ptr=6; req=8'h41 re-raised -> id 0 is granted before id 6.
